// File: rtl/decoder_n_to_2n_seq.sv
// rtl/decoder_n_to_2n_seq.sv - registered N-to-2**N one-hot decoder with optional auto-scan
//
// Purpose:
//   Accepts a select index over a valid/ready handshake and presents the
//   matching one-hot code on a registered output one clock later. When built
//   with DECODER_SCAN_EN defined, raising scan_mode walks a single hot bit
//   across the output, advancing one position every SCAN_DIV clocks. Without
//   the macro, scan_mode is accepted on the port but has no effect.
//
// Ports:
//   clk        in   clock, all state changes on the rising edge
//   rst_n      in   synchronous active-low reset
//   enable     in   block enable; low forces IDLE with a zero output
//   sel        in   [SEL_W-1:0] index to decode
//   sel_valid  in   sel is valid this cycle
//   sel_ready  out  block accepts sel this cycle
//   scan_mode  in   auto-scan request (used only with DECODER_SCAN_EN)
//   d_out      out  [2**SEL_W-1:0] registered one-hot (or all-zero) code
//   d_valid    out  d_out holds a valid one-hot code

module decoder_n_to_2n_seq #(
  parameter int SEL_W    = 3,
  parameter int SCAN_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  sel_valid,
  output logic                  sel_ready,
  input  logic                  scan_mode,
  output logic [(1<<SEL_W)-1:0] d_out,
  output logic                  d_valid
);

  localparam int N = 1 << SEL_W;
  localparam logic [N-1:0] ONE = N'(1);

`ifdef DECODER_SCAN_EN
  typedef enum logic [1:0] {IDLE, DRIVE, SCAN} state_t;
`else
  typedef enum logic [1:0] {IDLE, DRIVE} state_t;
`endif

  state_t         state_q;
  logic [N-1:0]   d_out_q;
  logic           d_valid_q;
  logic [N-1:0]   decode_d;
  logic           scan_active;

  assign decode_d = ONE << sel;

`ifdef DECODER_SCAN_EN
  localparam logic [7:0] DIV_LAST = 8'(SCAN_DIV - 1);

  logic [7:0]   div_q;
  logic [N-1:0] rot_d;

  // Hot bit moves toward the MSB and wraps from bit N-1 back to bit 0.
  assign rot_d       = {d_out_q[N-2:0], d_out_q[N-1]};
  assign scan_active = scan_mode;
`else
  logic unused_scan_mode;

  assign unused_scan_mode = scan_mode;
  assign scan_active      = 1'b0;
`endif

  assign sel_ready = rst_n & enable & ~scan_active;
  assign d_out     = d_out_q;
  assign d_valid   = d_valid_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      d_out_q   <= '0;
      d_valid_q <= 1'b0;
`ifdef DECODER_SCAN_EN
      div_q     <= 8'd0;
`endif
    end else if (!enable) begin
      state_q   <= IDLE;
      d_out_q   <= '0;
      d_valid_q <= 1'b0;
`ifdef DECODER_SCAN_EN
      div_q     <= 8'd0;
    end else if (scan_mode) begin
      // Scan wins over any simultaneous sel_valid; entry always restarts at bit 0.
      if (state_q != SCAN) begin
        state_q   <= SCAN;
        d_out_q   <= ONE;
        d_valid_q <= 1'b1;
        div_q     <= 8'd0;
      end else if (div_q == DIV_LAST) begin
        d_out_q <= rot_d;
        div_q   <= 8'd0;
      end else begin
        div_q <= div_q + 8'd1;
      end
    end else if (state_q == SCAN) begin
      // Leaving scan always lands in IDLE, even if sel_valid is up this cycle.
      state_q   <= IDLE;
      d_out_q   <= '0;
      d_valid_q <= 1'b0;
      div_q     <= 8'd0;
`endif
    end else if (sel_valid) begin
      state_q   <= DRIVE;
      d_out_q   <= decode_d;
      d_valid_q <= 1'b1;
    end else if (state_q == IDLE) begin
      d_out_q   <= '0;
      d_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decoder_n_to_2n_seq.sv
// tb/tb_decoder_n_to_2n_seq.sv - self-checking bench for decoder_n_to_2n_seq
//
// Purpose:
//   Directed scenarios with literal expectations, then randomized stimulus
//   checked every cycle against a behavioural model of the decoder.
//   Honours DECODER_SCAN_EN the same way the design does.

module tb_decoder_n_to_2n_seq;

  localparam int SEL_W    = 3;
  localparam int SCAN_DIV = 4;
  localparam int N        = 1 << SEL_W;

`ifdef DECODER_SCAN_EN
  localparam bit SCAN_EN = 1'b1;
`else
  localparam bit SCAN_EN = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             enable;
  logic [SEL_W-1:0] sel;
  logic             sel_valid;
  logic             sel_ready;
  logic             scan_mode;
  logic [N-1:0]     d_out;
  logic             d_valid;

  int checks   = 0;
  int failures = 0;

  decoder_n_to_2n_seq #(.SEL_W(SEL_W), .SCAN_DIV(SCAN_DIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .sel       (sel),
    .sel_valid (sel_valid),
    .sel_ready (sel_ready),
    .scan_mode (scan_mode),
    .d_out     (d_out),
    .d_valid   (d_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 = idle, 1 = showing decoded index, 2 = scanning.
  int m_mode = 0;
  int m_idx  = 0;
  int m_k    = 0;

  function automatic logic [N-1:0] model_out();
    logic [N-1:0] one;
    one = N'(1);
    if (m_mode == 1) return one << m_idx;
    if (m_mode == 2) return one << ((m_k / SCAN_DIV) % N);
    return '0;
  endfunction

  always @(posedge clk) begin
    logic exp_rdy;
    exp_rdy = rst_n && enable && !(SCAN_EN && scan_mode);
    chk("sel_ready", {31'd0, sel_ready}, {31'd0, exp_rdy});
    if (!rst_n || !enable) begin
      m_mode = 0;
    end else if (SCAN_EN && scan_mode) begin
      if (m_mode != 2) begin
        m_mode = 2;
        m_k    = 0;
      end else begin
        m_k++;
      end
    end else if (m_mode == 2) begin
      m_mode = 0;
    end else if (sel_valid) begin
      m_mode = 1;
      m_idx  = int'(sel);
    end
    #1;
    chk("d_out_model", 32'(d_out), 32'(model_out()));
    chk("d_valid_model", {31'd0, d_valid}, {31'd0, (m_mode != 0)});
    chk("onehot_or_zero", {31'd0, ($countones(d_out) <= 1)}, 32'd1);
  end

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; sel = '0; sel_valid = 1'b0; scan_mode = 1'b0;
    cyc(3);
    chk("reset_d_out", 32'(d_out), 32'h0);
    chk("reset_d_valid", {31'd0, d_valid}, 32'd0);
    chk("reset_sel_ready", {31'd0, sel_ready}, 32'd0);

    // Single accept, then hold.
    rst_n = 1'b1; enable = 1'b1;
    sel = 3'd5; sel_valid = 1'b1;
    cyc();
    sel_valid = 1'b0; sel = 3'd1;
    chk("sel5_d_out", 32'(d_out), 32'h20);
    chk("sel5_d_valid", {31'd0, d_valid}, 32'd1);
    cyc(3);
    chk("sel5_hold", 32'(d_out), 32'h20);

    // Back-to-back accepts.
    sel_valid = 1'b1;
    sel = 3'd0; cyc(); chk("b2b_0", 32'(d_out), 32'h01);
    sel = 3'd7; cyc(); chk("b2b_7", 32'(d_out), 32'h80);
    sel = 3'd3; cyc(); chk("b2b_3", 32'(d_out), 32'h08);

    // Disable while driving with sel_valid high.
    enable = 1'b0; sel = 3'd6; sel_valid = 1'b1;
    #1;
    chk("disable_sel_ready", {31'd0, sel_ready}, 32'd0);
    cyc();
    chk("disable_d_out", 32'(d_out), 32'h0);
    chk("disable_d_valid", {31'd0, d_valid}, 32'd0);
    cyc();
    chk("disable_no_capture", 32'(d_out), 32'h0);
    enable = 1'b1; sel_valid = 1'b0;
    cyc();

`ifdef DECODER_SCAN_EN
    scan_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      sel_valid = 1'b1;
      sel = 3'($urandom_range(0, 7));
      cyc();
      chk("scan_sel_ready", {31'd0, sel_ready}, 32'd0);
      if (i == 0)  chk("scan_c0",  32'(d_out), 32'h01);
      if (i == 3)  chk("scan_c3",  32'(d_out), 32'h01);
      if (i == 4)  chk("scan_c4",  32'(d_out), 32'h02);
      if (i == 28) chk("scan_c28", 32'(d_out), 32'h80);
      if (i == 32) chk("scan_wrap", 32'(d_out), 32'h01);
    end
    scan_mode = 1'b0; sel_valid = 1'b0;
    cyc();
    chk("scan_exit_d_out", 32'(d_out), 32'h0);
    chk("scan_exit_d_valid", {31'd0, d_valid}, 32'd0);
    scan_mode = 1'b1;
    cyc(17);
    chk("scan_at_0x10", 32'(d_out), 32'h10);
    rst_n = 1'b0;
    cyc();
    chk("scan_reset_d_out", 32'(d_out), 32'h0);
    chk("scan_reset_d_valid", {31'd0, d_valid}, 32'd0);
    rst_n = 1'b1; scan_mode = 1'b0;
    cyc();
`else
    scan_mode = 1'b1; sel = 3'd2; sel_valid = 1'b1;
    #1;
    chk("noscan_sel_ready", {31'd0, sel_ready}, 32'd1);
    cyc();
    sel_valid = 1'b0;
    chk("noscan_d_out", 32'(d_out), 32'h04);
    cyc(6);
    chk("noscan_no_rotate", 32'(d_out), 32'h04);
    scan_mode = 1'b0;
`endif

    // Randomized phase; scan_mode toggles rarely so scans run long enough to rotate.
    for (int i = 0; i < 3000; i++) begin
      rst_n     = ($urandom_range(0, 99) >= 2);
      enable    = ($urandom_range(0, 99) >= 8);
      if ($urandom_range(0, 99) < 4) scan_mode = ~scan_mode;
      sel_valid = $urandom_range(0, 1) == 1;
      sel       = 3'($urandom_range(0, N - 1));
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
